uart_rs232_tx: RTL and testbench

Frame-level RS-232 transmitter and the transmit-side counterpart of the project's UART receiver. It serialises one 6/7/8-bit character per request into a standard asynchronous frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits. Bit periods are timed from the shared 16x-oversample baud tick. It sits between the byte-producing logic (command/response FSM) and the Tx pin. It uses a single-clock design with Tick as a clock enable.

---
 rtl/uart_rs232_tx.sv | 125 ++++++++++++
 tb/tb_uart_rs232_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rs232_tx.sv
// RS-232 frame transmitter: start bit, 6/7/8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Bit periods are OVERSAMPLE baud ticks long; Tick acts as a clock enable.
module uart_rs232_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Tick,
  input  logic       TxEn,
  input  logic       TxStart,
  input  logic [7:0] TxData,
  input  logic [3:0] NBits,
  input  logic       ParityEn,
  input  logic       ParityOdd,
  input  logic       TwoStop,
  output logic       Tx,
  output logic       TxBusy,
  output logic       TxDone
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [3:0]       nbits_q;
  logic             par_en_q;
  logic             par_q;
  logic             two_stop_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       nbits_d;
  logic             period_end;
  logic             last_data;

  // Unsupported widths fall back to a full byte.
  assign nbits_d    = (NBits == 4'd6 || NBits == 4'd7) ? NBits : 4'd8;
  assign period_end = Tick && (tick_cnt_q == CNT_W'(OVERSAMPLE - 1));
  assign last_data  = (bit_cnt_q == nbits_q - 4'd1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (TxStart && TxEn) begin
          shift_q    <= TxData;
          nbits_q    <= nbits_d;
          par_en_q   <= ParityEn;
          par_q      <= ParityOdd;
          two_stop_q <= TwoStop;
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          state_q    <= START;
          tx_q       <= 1'b0;
          busy_q     <= 1'b1;
        end
      end else begin
        if (Tick) begin
          tick_cnt_q <= period_end ? '0 : tick_cnt_q + 1'b1;
        end
        // Tx is loaded with the level of the next bit on the edge the current one ends.
        if (period_end) begin
          case (state_q)
            START: begin
              state_q <= DATA;
              tx_q    <= shift_q[0];
            end
            DATA: begin
              par_q     <= par_q ^ shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (!last_data) begin
                tx_q <= shift_q[1];
              end else if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_q ^ shift_q[0];
              end else begin
                state_q   <= STOP;
                bit_cnt_q <= '0;
                tx_q      <= 1'b1;
              end
            end
            PARITY: begin
              state_q   <= STOP;
              bit_cnt_q <= '0;
              tx_q      <= 1'b1;
            end
            STOP: begin
              if (two_stop_q && bit_cnt_q == 4'd0) begin
                bit_cnt_q <= 4'd1;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign Tx     = tx_q;
  assign TxBusy = busy_q;
  assign TxDone = done_q;

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Self-checking bench for uart_rs232_tx: each frame is compared tick by tick against
// a bit list built from the framing rules (start, data LSB first, parity, stops).
module tb_uart_rs232_tx;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Tick = 1'b0;
  logic       TxEn;
  logic       TxStart;
  logic [7:0] TxData;
  logic [3:0] NBits;
  logic       ParityEn;
  logic       ParityOdd;
  logic       TwoStop;
  logic       Tx;
  logic       TxBusy;
  logic       TxDone;

  int pass_cnt = 0;
  int total_cnt = 0;

  int cyc = 0;
  int tick_div = 4;
  bit tick_jitter = 1'b0;

  logic exp_bits[$];
  logic samples[$];
  bit   busy_bad;

  uart_rs232_tx #(.OVERSAMPLE(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Tick(Tick), .TxEn(TxEn), .TxStart(TxStart),
    .TxData(TxData), .NBits(NBits), .ParityEn(ParityEn), .ParityOdd(ParityOdd),
    .TwoStop(TwoStop), .Tx(Tx), .TxBusy(TxBusy), .TxDone(TxDone)
  );

  always #5 Clk = ~Clk;

  // Tick changes just after the rising edge so it is stable when sampled on the falling edge.
  always @(posedge Clk) begin
    #1;
    cyc = cyc + 1;
    if (tick_jitter) Tick = ($urandom_range(0, 2) == 0);
    else             Tick = ((cyc % tick_div) == 0);
  end

  // Expected line levels, one entry per bit period.
  function automatic void build_frame(input logic [7:0] d, input logic [3:0] nb,
                                      input bit pen, input bit podd, input bit two);
    int n;
    int ones;
    n = (nb == 4'd6 || nb == 4'd7) ? int'(nb) : 8;
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_bits.push_back(((ones + int'(podd)) % 2) == 1);
    exp_bits.push_back(1'b1);
    if (two) exp_bits.push_back(1'b1);
  endfunction

  function automatic int first_diff();
    if (samples.size() != exp_bits.size() * 16) return -2;
    foreach (samples[i]) if (samples[i] !== exp_bits[i / 16]) return i;
    return -1;
  endfunction

  task automatic request(input logic [7:0] d, input logic [3:0] nb,
                         input bit pen, input bit podd, input bit two);
    @(negedge Clk);
    TxData = d; NBits = nb; ParityEn = pen; ParityOdd = podd; TwoStop = two;
    TxStart = 1'b1;
    @(negedge Clk);
    TxStart = 1'b0;
  endtask

  // Records Tx at every counted Tick while scrambling the frame inputs; returns on the
  // falling edge after the last expected tick.
  task automatic capture(input int nticks, input bit hold_start);
    int guard;
    guard = 0;
    samples.delete();
    busy_bad = 1'b0;
    while (samples.size() < nticks && guard < 20000) begin
      if (Tick) begin
        samples.push_back(Tx);
        if (TxBusy !== 1'b1 || TxDone !== 1'b0) busy_bad = 1'b1;
      end
      TxData = 8'($urandom); NBits = 4'($urandom); ParityEn = 1'($urandom);
      ParityOdd = 1'($urandom); TwoStop = 1'($urandom);
      if (hold_start) TxStart = 1'b1;
      @(negedge Clk);
      guard++;
    end
  endtask

  task automatic wait_ticks(input int n);
    int c;
    int g;
    c = 0; g = 0;
    while (c < n && g < 20000) begin
      if (Tick) c++;
      @(negedge Clk);
      g++;
    end
  endtask

  task automatic test_reset();
    bit bad;
    Rst_n = 1'b0; TxStart = 1'b0; TxEn = 1'b1; TxData = 8'h00; NBits = 4'd8;
    ParityEn = 1'b0; ParityOdd = 1'b0; TwoStop = 1'b0;
    repeat (3) @(negedge Clk);
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b100)
      $display("FAIL reset_state: got {Tx,Busy,Done}=%b need 100", {Tx, TxBusy, TxDone});
    else pass_cnt++;
    Rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      if ({Tx, TxBusy, TxDone} !== 3'b100) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL idle_after_reset: line left idle without request, got %b need 0", bad);
    else pass_cnt++;
    $display("reset: idle line checked");
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic [3:0] nb,
                            input bit pen, input bit podd, input bit two);
    int diff;
    build_frame(d, nb, pen, podd, two);
    request(d, nb, pen, podd, two);
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b010)
      $display("FAIL %s accept: got {Tx,Busy,Done}=%b need 010", name, {Tx, TxBusy, TxDone});
    else pass_cnt++;
    capture(exp_bits.size() * 16, 1'b0);
    diff = first_diff();
    total_cnt++;
    if (diff != -1)
      $display("FAIL %s waveform: first bad tick %0d, got %0d samples need %0d",
               name, diff, samples.size(), exp_bits.size() * 16);
    else pass_cnt++;
    total_cnt++;
    if (busy_bad) $display("FAIL %s busy: got busy_bad=%b need 0", name, busy_bad);
    else pass_cnt++;
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b101)
      $display("FAIL %s end: got {Tx,Busy,Done}=%b need 101", name, {Tx, TxBusy, TxDone});
    else pass_cnt++;
    @(negedge Clk);
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b100)
      $display("FAIL %s done_width: got {Tx,Busy,Done}=%b need 100", name, {Tx, TxBusy, TxDone});
    else pass_cnt++;
    $display("frame %s: data=%h nbits=%0d par=%b odd=%b two=%b ticks=%0d",
             name, d, nb, pen, podd, two, samples.size());
  endtask

  task automatic test_back_to_back();
    logic [7:0] d1;
    logic [7:0] d2;
    int diff;
    tick_div = 3; tick_jitter = 1'b0;
    d1 = 8'($urandom); d2 = 8'($urandom);
    build_frame(d1, 4'd8, 1'b1, 1'b0, 1'b0);
    request(d1, 4'd8, 1'b1, 1'b0, 1'b0);
    capture(exp_bits.size() * 16, 1'b1);
    diff = first_diff();
    total_cnt++;
    if (diff != -1 || busy_bad)
      $display("FAIL b2b_first_frame: first bad tick %0d busy_bad=%b, need -1 and 0", diff, busy_bad);
    else pass_cnt++;
    total_cnt++;
    if ({TxBusy, TxDone} !== 2'b01)
      $display("FAIL b2b_done: got {Busy,Done}=%b need 01", {TxBusy, TxDone});
    else pass_cnt++;
    TxData = d2; NBits = 4'd7; ParityEn = 1'b0; ParityOdd = 1'b0; TwoStop = 1'b1;
    build_frame(d2, 4'd7, 1'b0, 1'b0, 1'b1);
    @(negedge Clk);
    TxStart = 1'b0;
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b010)
      $display("FAIL b2b_no_gap: got {Tx,Busy,Done}=%b need 010", {Tx, TxBusy, TxDone});
    else pass_cnt++;
    capture(exp_bits.size() * 16, 1'b0);
    diff = first_diff();
    total_cnt++;
    if (diff != -1 || {TxBusy, TxDone} !== 2'b01)
      $display("FAIL b2b_second_frame: first bad tick %0d {Busy,Done}=%b, need -1 and 01",
               diff, {TxBusy, TxDone});
    else pass_cnt++;
    $display("back_to_back: frames %h then %h", d1, d2);
  endtask

  task automatic test_async_reset();
    bit bad;
    tick_div = 2; tick_jitter = 1'b0;
    request(8'h96, 4'd8, 1'b1, 1'b1, 1'b1);
    wait_ticks(16 * 4);
    #3 Rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({Tx, TxBusy, TxDone} !== 3'b100)
      $display("FAIL async_reset: got {Tx,Busy,Done}=%b need 100", {Tx, TxBusy, TxDone});
    else pass_cnt++;
    #2 Rst_n = 1'b1;
    bad = 1'b0;
    repeat (100) begin
      @(negedge Clk);
      if ({Tx, TxBusy, TxDone} !== 3'b100) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL no_resume: partial frame resumed, got %b need 0", bad);
    else pass_cnt++;
    $display("async_reset: frame aborted mid-data");
    test_frame("8N1_3C_after_rst", 8'h3C, 4'd8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_txen();
    bit bad;
    int diff;
    tick_div = 4; tick_jitter = 1'b0;
    TxEn = 1'b0;
    request(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    bad = 1'b0;
    repeat (40) begin
      if ({Tx, TxBusy, TxDone} !== 3'b100) bad = 1'b1;
      @(negedge Clk);
    end
    total_cnt++;
    if (bad) $display("FAIL txen_refuse: frame started with TxEn=0, got %b need 0", bad);
    else pass_cnt++;
    TxEn = 1'b1;
    build_frame(8'hC3, 4'd8, 1'b1, 1'b0, 1'b0);
    request(8'hC3, 4'd8, 1'b1, 1'b0, 1'b0);
    TxEn = 1'b0;
    total_cnt++;
    if ({Tx, TxBusy} !== 2'b01)
      $display("FAIL txen_accept: got {Tx,Busy}=%b need 01", {Tx, TxBusy});
    else pass_cnt++;
    capture(exp_bits.size() * 16, 1'b0);
    diff = first_diff();
    total_cnt++;
    if (diff != -1 || {Tx, TxBusy, TxDone} !== 3'b101)
      $display("FAIL txen_drop_completes: first bad tick %0d {Tx,Busy,Done}=%b, need -1 and 101",
               diff, {Tx, TxBusy, TxDone});
    else pass_cnt++;
    request(8'h0F, 4'd8, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if ({Tx, TxBusy} !== 2'b10)
      $display("FAIL txen_refuse_after: got {Tx,Busy}=%b need 10", {Tx, TxBusy});
    else pass_cnt++;
    TxEn = 1'b1;
    $display("txen: refusal and mid-frame drop checked");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      tick_jitter = 1'($urandom_range(0, 1));
      tick_div = $urandom_range(1, 5);
      test_frame($sformatf("rand%0d", i), 8'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_frame("8N1_A5", 8'hA5, 4'd8, 1'b0, 1'b0, 1'b0);
    test_frame("7E2_41", 8'h41, 4'd7, 1'b1, 1'b0, 1'b1);
    test_frame("7O2_41", 8'h41, 4'd7, 1'b1, 1'b1, 1'b1);
    test_frame("NBitsF_FF", 8'hFF, 4'hF, 1'b0, 1'b0, 1'b0);
    test_frame("6O1_FF", 8'hFF, 4'd6, 1'b1, 1'b1, 1'b0);
    test_back_to_back();
    test_async_reset();
    test_txen();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
